// File: rtl/bus_timer_resp.sv
// rtl/bus_timer_resp.sv - memory-mapped prescaled down-counter timer with bus read responder
//
// Purpose: 8-word register window at BASE_ADDR on the CPU memory bus. A
//   16-bit down-counter, paced by a programmable prescaler, sets STATUS.expired
//   when it runs out and raises Irq when interrupts are enabled.
//   Optional build macro: TIMER_READ_CLEAR_EN (a STATUS read also clears expired).
//
// Registers (word offset within the window):
//   0 CTRL   [0] en, [1] reload, [2] ie
//   1 LOAD   reload / start value
//   2 COUNT  current count, read-only
//   3 PRESC  prescaler terminal value (0 = tick every cycle)
//   4 STATUS [0] expired, write-1-to-clear
//   5-7      read as zero, writes ignored
//
// Ports:
//   Clk1     in   system clock, rising edge
//   Reset    in   synchronous active-high reset
//   Addr     in   16-bit word address from the CPU
//   RD, WR   in   read / write strobes (write wins when both are high)
//   DataOut  in   CPU write data
//   DataIn   out  registered read data, valid while Sel is high
//   Sel      out  high for the one cycle after an accepted read
//   Irq      out  level interrupt = expired & ie

module bus_timer_resp #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DATA_W    = 16
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [15:0]       Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataOut,
  output logic [DATA_W-1:0] DataIn,
  output logic              Sel,
  output logic              Irq
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic              ctrl_reload;
  logic              ctrl_ie;
  logic [DATA_W-1:0] load;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] presc;
  logic [DATA_W-1:0] pcnt;
  logic              expired;

  logic              hit;
  logic [2:0]        off;
  logic              rd_fire;
  logic              ctrl_wr;
  logic              load_wr;
  logic              presc_wr;
  logic              status_wr;
  logic              rd_clr;
  logic              w1c;
  logic [DATA_W-1:0] rdata;

  // FSM outputs
  logic              run;
  logic              tick;
  logic              expire;
  logic              start;

  // Bus decode
  assign hit       = (Addr[15:3] == BASE_ADDR[15:3]);
  assign off       = Addr[2:0];
  assign rd_fire   = RD & hit & ~WR;
  assign ctrl_wr   = WR & hit & (off == 3'd0);
  assign load_wr   = WR & hit & (off == 3'd1);
  assign presc_wr  = WR & hit & (off == 3'd3);
  assign status_wr = WR & hit & (off == 3'd4);
  assign w1c       = status_wr & DataOut[0];

`ifdef TIMER_READ_CLEAR_EN
  assign rd_clr = rd_fire & (off == 3'd4);
`else
  assign rd_clr = 1'b0;
`endif

  // State register; the en bit of CTRL is the state itself.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a CTRL write always dictates en, even on an expiry edge.
  always_comb begin
    state_next = state;
    if (ctrl_wr) begin
      state_next = DataOut[0] ? RUN : IDLE;
    end else if (expire && !ctrl_reload) begin
      state_next = IDLE;
    end
  end

  // FSM outputs
  always_comb begin
    run    = (state == RUN);
    tick   = run && (pcnt == presc);
    expire = tick && (count == '0);
    start  = ctrl_wr && DataOut[0] && (state == IDLE);
  end

  // Read mux, sampled at the edge the read is accepted.
  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata[2:0] = {ctrl_ie, ctrl_reload, run};
      3'd1:    rdata = load;
      3'd2:    rdata = count;
      3'd3:    rdata = presc;
      3'd4:    rdata[0] = expired;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      ctrl_reload <= 1'b0;
      ctrl_ie     <= 1'b0;
      load        <= '0;
      presc       <= '0;
      count       <= '0;
      pcnt        <= '0;
      expired     <= 1'b0;
      DataIn      <= '0;
      Sel         <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_reload <= DataOut[1];
        ctrl_ie     <= DataOut[2];
      end
      if (load_wr) begin
        load <= DataOut;
      end
      if (presc_wr) begin
        presc <= DataOut;
      end

      // Counting only continues if we are still running after this edge;
      // clearing en freezes COUNT where it is. LOAD is only consulted on
      // enable or reload, so a LOAD write mid-run leaves COUNT alone.
      if (start) begin
        count <= load;
      end else if (tick && (state_next == RUN)) begin
        if (count != '0) begin
          count <= count - ONE;
        end else if (ctrl_reload) begin
          count <= load;
        end
      end

      if ((state_next == IDLE) || start || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + ONE;
      end

      // Setting beats any clear arriving on the same edge.
      expired <= expire | (expired & ~(w1c | rd_clr));

      Sel <= rd_fire;
      if (rd_fire) begin
        DataIn <= rdata;
      end
    end
  end

  assign Irq = expired & ctrl_ie;

endmodule

// File: tb/tb_bus_timer_resp.sv
// tb/tb_bus_timer_resp.sv - directed table-driven bench for bus_timer_resp

module tb_bus_timer_resp;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        sel;
  logic        irq;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        sel;
    logic        chk_data;
    logic [15:0] data;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  bus_timer_resp #(.BASE_ADDR(16'hFF00), .DATA_W(16)) dut (
    .Clk1   (clk),
    .Reset  (rst),
    .Addr   (addr),
    .RD     (rd),
    .WR     (wr),
    .DataOut(dout),
    .DataIn (din),
    .Sel    (sel),
    .Irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one bus cycle; returns 1 time unit after the sampling edge.
  task automatic bus(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd   = r;
    wr   = w;
    addr = a;
    dout = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic s, input logic cd, input logic [15:0] x, input logic q);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
    v.sel = s; v.chk_data = cd; v.data = x; v.irq = q;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; dout = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_datain", din, 16'h0000);
    chk("reset_sel", {15'b0, sel}, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    rst = 1'b0;

    //   rd    wr    addr      wdata     sel  chkd data      irq
    add(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF04, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    // one-shot: LOAD=3, PRESC=0, CTRL=en|ie
    add(1'b0, 1'b1, 16'hFF01, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b0);
    add(1'b0, 1'b1, 16'hFF03, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0);
    add(1'b0, 1'b1, 16'hFF00, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1);
    add(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b1);
    add(1'b0, 1'b1, 16'hFF04, 16'h0001, 1'b0, 1'b1, 16'h0004, 1'b0);
    add(1'b1, 1'b0, 16'hFF04, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    // decode and read/write collisions
    add(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0);
    add(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0);
    add(1'b1, 1'b0, 16'hFF07, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b1, 16'hFF01, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0);
    add(1'b0, 1'b1, 16'hFF02, 16'h5555, 1'b0, 1'b1, 16'h1234, 1'b0);
    add(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);
    add(1'b0, 1'b1, 16'h0101, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0);
    add(1'b0, 1'b1, 16'hFF05, 16'hFFFF, 1'b0, 1'b1, 16'h1234, 1'b0);
    add(1'b1, 1'b0, 16'hFF05, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_sel", i), {15'b0, sel}, {15'b0, vecs[i].sel});
      chk($sformatf("vec%0d_irq", i), {15'b0, irq}, {15'b0, vecs[i].irq});
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), din, vecs[i].data);
    end

    // Auto-reload, LOAD=2 PRESC=1: expiry every 6 cycles; W1C at 7 and 13,
    // and a W1C coincident with the expiry at 18.
    bus(1'b0, 1'b1, 16'hFF01, 16'h0002);
    bus(1'b0, 1'b1, 16'hFF03, 16'h0001);
    bus(1'b0, 1'b1, 16'hFF00, 16'h0007);
    for (int c = 1; c <= 18; c++) begin
      if (c == 7 || c == 13 || c == 18) bus(1'b0, 1'b1, 16'hFF04, 16'h0001);
      else bus(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk($sformatf("reload_irq_c%0d", c), {15'b0, irq},
          {15'b0, (c == 6 || c == 12 || c == 18)});
    end
    bus(1'b0, 1'b1, 16'hFF00, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0001);
    chk("reload_stop_irq", {15'b0, irq}, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    chk("reload_stop_ctrl", din, 16'h0000);

    // Stop mid-count: LOAD=10, four ticks, then clear en.
    bus(1'b0, 1'b1, 16'hFF01, 16'h000A);
    bus(1'b0, 1'b1, 16'hFF03, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF00, 16'h0005);
    repeat (4) bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF00, 16'h0004);
    repeat (3) bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF02, 16'h0000);
    chk("stop_count", din, 16'h0006);
    chk("stop_sel", {15'b0, sel}, 16'h0001);
    chk("stop_irq", {15'b0, irq}, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF00, 16'h0000);
    chk("stop_ctrl", din, 16'h0004);

    // Reset mid-run with expired set and DataIn non-zero.
    bus(1'b0, 1'b1, 16'hFF01, 16'h0001);
    bus(1'b0, 1'b1, 16'hFF00, 16'h0007);
    repeat (3) bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF01, 16'h0000);
    chk("prerst_data", din, 16'h0001);
    chk("prerst_irq", {15'b0, irq}, 16'h0001);
    rst = 1'b1;
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    chk("midrst_datain", din, 16'h0000);
    chk("midrst_sel", {15'b0, sel}, 16'h0000);
    chk("midrst_irq", {15'b0, irq}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      bus(1'b1, 1'b0, 16'hFF00 + 16'(i), 16'h0000);
      chk($sformatf("midrst_reg%0d", i), din, 16'h0000);
    end

    // STATUS read behaviour after an expiry (LOAD=0, one-shot).
    bus(1'b0, 1'b1, 16'hFF01, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF00, 16'h0005);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0000);
    chk("status_read1", din, 16'h0001);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0000);
`ifdef TIMER_READ_CLEAR_EN
    chk("status_read2", din, 16'h0000);
    chk("status_read2_irq", {15'b0, irq}, 16'h0000);
`else
    chk("status_read2", din, 16'h0001);
    chk("status_read2_irq", {15'b0, irq}, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
